// File: rtl/step_controller_if.sv
// rtl/step_controller_if.sv - control/debug bus between the step controller and its host
interface step_controller_if;
   logic        step_btn;
   logic        run_sw;
   logic [4:0]  sel;
   logic [31:0] pc_in;
   logic [31:0] dbg_data;
   logic [4:0]  dbg_sel;
   logic        cpu_ce;
   logic [15:0] cycle_cnt;
   logic [3:0]  an;
   logic [6:0]  seg;

   modport master (
      output step_btn, run_sw, sel, pc_in, dbg_data,
      input  dbg_sel, cpu_ce, cycle_cnt, an, seg
   );

   modport slave (
      input  step_btn, run_sw, sel, pc_in, dbg_data,
      output dbg_sel, cpu_ce, cycle_cnt, an, seg
   );
endinterface

// File: rtl/step_controller.sv
// rtl/step_controller.sv - single-step / free-run pipeline clock enable with 4-digit hex debug display
module step_controller #(
   parameter int DEB_CYCLES = 100000,
   parameter int SCAN_DIV   = 100000,
   parameter int RUN_DIV    = 1
) (
   input  logic             clk,
   input  logic             reset,
   step_controller_if.slave bus
);
   localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int RUN_W  = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
   localparam logic [DEB_W-1:0]  DEB_MAX  = DEB_W'(DEB_CYCLES - 1);
   localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);
   localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(RUN_DIV - 1);

   typedef enum logic [1:0] {
      S_HALT,
      S_STEP,
      S_RUN
   } state_t;

   state_t             state_q, state_d;
   logic               sync1_q, sync1_d;
   logic               sync2_q, sync2_d;
   logic               deb_level_q, deb_level_d;
   logic [DEB_W-1:0]   deb_cnt_q, deb_cnt_d;
   logic [RUN_W-1:0]   div_q, div_d;
   logic [15:0]        cycle_cnt_q, cycle_cnt_d;
   logic [4:0]         dbg_sel_q, dbg_sel_d;
   logic [SCAN_W-1:0]  scan_q, scan_d;
   logic [3:0]         an_q, an_d;
   logic [15:0]        disp_q, disp_d;
   logic [6:0]         seg_q, seg_d;
   logic               step_pulse;
   logic               cpu_ce;
   logic [3:0]         nibble;
   logic               unused_hi;

   assign unused_hi = ^{bus.pc_in[31:16], bus.dbg_data[31:16]};

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0:    hex7 = 7'b0000001;
         4'h1:    hex7 = 7'b1001111;
         4'h2:    hex7 = 7'b0010010;
         4'h3:    hex7 = 7'b0000110;
         4'h4:    hex7 = 7'b1001100;
         4'h5:    hex7 = 7'b0100100;
         4'h6:    hex7 = 7'b0100000;
         4'h7:    hex7 = 7'b0001111;
         4'h8:    hex7 = 7'b0000000;
         4'h9:    hex7 = 7'b0000100;
         4'hA:    hex7 = 7'b0001000;
         4'hB:    hex7 = 7'b1100000;
         4'hC:    hex7 = 7'b0110001;
         4'hD:    hex7 = 7'b1000010;
         4'hE:    hex7 = 7'b0110000;
         default: hex7 = 7'b0111000;
      endcase
   endfunction

   // Button path: two-flop synchronizer, then a level that flips only after a full run of disagreement.
   always_comb begin
      sync1_d     = bus.step_btn;
      sync2_d     = sync1_q;
      deb_level_d = deb_level_q;
      deb_cnt_d   = '0;
      step_pulse  = 1'b0;
      if (sync2_q != deb_level_q) begin
         if (deb_cnt_q == DEB_MAX) begin
            deb_level_d = sync2_q;
            step_pulse  = sync2_q;
         end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
         end
      end
   end

   // Step requests arriving with run_sw high are dropped: RUN takes priority.
   always_comb begin
      state_d = state_q;
      div_d   = '0;
      cpu_ce  = 1'b0;
      case (state_q)
         S_HALT: begin
            if (bus.run_sw) begin
               state_d = S_RUN;
            end else if (step_pulse) begin
               state_d = S_STEP;
            end
         end
         S_STEP: begin
            cpu_ce  = 1'b1;
            state_d = S_HALT;
         end
         S_RUN: begin
            if (!bus.run_sw) begin
               state_d = S_HALT;
            end else if (div_q == RUN_MAX) begin
               cpu_ce = 1'b1;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         default: state_d = S_HALT;
      endcase
      cycle_cnt_d = cpu_ce ? cycle_cnt_q + 16'd1 : cycle_cnt_q;
   end

   // Display scan: value and digit advance together so seg always matches the lit anode.
   always_comb begin
      dbg_sel_d = bus.sel;
      scan_d    = scan_q + 1'b1;
      an_d      = an_q;
      disp_d    = disp_q;
      if (scan_q == SCAN_MAX) begin
         scan_d = '0;
         an_d   = {an_q[0], an_q[3:1]};
         disp_d = (dbg_sel_q == 5'b00000) ? bus.pc_in[15:0] : bus.dbg_data[15:0];
      end
      case (an_d)
         4'b1110: nibble = disp_d[3:0];
         4'b1101: nibble = disp_d[7:4];
         4'b1011: nibble = disp_d[11:8];
         default: nibble = disp_d[15:12];
      endcase
      seg_d = hex7(nibble);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_HALT;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         deb_level_q <= 1'b0;
         deb_cnt_q   <= '0;
         div_q       <= '0;
         cycle_cnt_q <= 16'd0;
         dbg_sel_q   <= 5'd0;
         scan_q      <= '0;
         an_q        <= 4'b1110;
         disp_q      <= 16'd0;
         seg_q       <= 7'b0000001;
      end else begin
         state_q     <= state_d;
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         deb_level_q <= deb_level_d;
         deb_cnt_q   <= deb_cnt_d;
         div_q       <= div_d;
         cycle_cnt_q <= cycle_cnt_d;
         dbg_sel_q   <= dbg_sel_d;
         scan_q      <= scan_d;
         an_q        <= an_d;
         disp_q      <= disp_d;
         seg_q       <= seg_d;
      end
   end

   assign bus.cpu_ce    = cpu_ce;
   assign bus.cycle_cnt = cycle_cnt_q;
   assign bus.dbg_sel   = dbg_sel_q;
   assign bus.an        = an_q;
   assign bus.seg       = seg_q;
endmodule
